mag_comp_seq: RTL and testbench

//   Parametrised multi-cycle magnitude comparator: generalises the 1-bit GT/EQ/LT

---
 rtl/mag_comp_seq.sv | 108 ++++++++++
 tb/tb_mag_comp_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mag_comp_seq.sv
`default_nettype none
// ============================================================================
// Module   : mag_comp_seq
// Purpose  : Multi-cycle magnitude comparator for wide operands. Compares
//            WIDTH-bit operands (signed or unsigned) CHUNK bits per cycle,
//            MSB chunk first, stopping at the first chunk that differs.
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous active-high reset
//            start        - compare request, sampled only while idle
//            signed_mode  - 1: two's-complement, 0: unsigned (latched with start)
//            a, b         - operands, latched on an accepted start
//            busy         - high while a compare is in progress
//            done         - one-cycle pulse when gt/eq/lt are updated
//            gt, eq, lt   - registered one-hot result, held until next done
// Revision : 1.0 - initial release
// ============================================================================
module mag_comp_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCH - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CMP  = 1'b1;

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("mag_comp_seq: WIDTH must be at least 2");
        end
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("mag_comp_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    logic [0:0]                r_state;
    logic [NCH-1:0][CHUNK-1:0] r_op_a;
    logic [NCH-1:0][CHUNK-1:0] r_op_b;
    logic [IDX_W-1:0]          r_idx;
    logic [WIDTH-1:0]          w_sign_flip;
    logic [CHUNK-1:0]          w_chunk_a;
    logic [CHUNK-1:0]          w_chunk_b;

    // Flipping the MSB of both operands maps two's-complement ordering onto
    // unsigned ordering, so the chunk compare below is always unsigned.
    assign w_sign_flip = {signed_mode, {(WIDTH-1){1'b0}}};

    assign w_chunk_a = r_op_a[r_idx];
    assign w_chunk_b = r_op_b[r_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_idx   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            gt      <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op_a  <= a ^ w_sign_flip;
                        r_op_b  <= b ^ w_sign_flip;
                        r_idx   <= IDX_TOP;
                        busy    <= 1'b1;
                        r_state <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    // The first differing chunk (from the top) decides the
                    // result; if every chunk matched, the operands are equal.
                    if ((w_chunk_a != w_chunk_b) || (r_idx == '0)) begin
                        gt      <= (w_chunk_a > w_chunk_b);
                        eq      <= (w_chunk_a == w_chunk_b);
                        lt      <= (w_chunk_a < w_chunk_b);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mag_comp_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mag_comp_seq
// Purpose  : Scoreboard bench for mag_comp_seq. Directed scenarios on an
//            8/2 instance plus randomized traffic on 8/2, 16/4 and 7/1
//            instances, checked against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mag_comp_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] flags;   // {gt, eq, lt}
        int         due;     // cycle count at which done must be seen
    } exp_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (bound expired or unexpected event)", name);
    endtask

    // Reference: compare operands as plain integers.
    function automatic logic [2:0] ref_cmp(input int w, input logic [31:0] x,
                                           input logic [31:0] y, input logic sm);
        longint vx = longint'(x);
        longint vy = longint'(y);
        if (sm && x[w-1]) vx -= (longint'(1) << w);
        if (sm && y[w-1]) vy -= (longint'(1) << w);
        if (vx > vy) return 3'b100;
        if (vx == vy) return 3'b010;
        return 3'b001;
    endfunction

    // Chunks examined: from the top down to the chunk holding the highest
    // differing bit (sign handling never changes which bits differ).
    function automatic int ref_lat(input int w, input int c, input logic [31:0] x,
                                   input logic [31:0] y);
        logic [31:0] d = x ^ y;
        int p = -1;
        for (int i = 0; i < w; i++) if (d[i]) p = i;
        if (p < 0) return w / c;
        return (w / c) - (p / c);
    endfunction

    // ------------------------------------------------------------------
    // Directed instance (WIDTH=8, CHUNK=2)
    // ------------------------------------------------------------------
    logic       d_rst = 1'b1, d_start = 1'b0, d_sm = 1'b0;
    logic [7:0] d_a = '0, d_b = '0;
    logic       d_busy, d_done, d_gt, d_eq, d_lt;
    exp_t       d_q[$];
    bit         d_fin = 1'b0;

    mag_comp_seq #(.WIDTH(8), .CHUNK(2)) dut_d (
        .clk(clk), .rst(d_rst), .start(d_start), .signed_mode(d_sm),
        .a(d_a), .b(d_b), .busy(d_busy), .done(d_done),
        .gt(d_gt), .eq(d_eq), .lt(d_lt)
    );

    initial begin : d_monitor
        exp_t e;
        bit   prev = 1'b0;
        forever begin
            @(negedge clk);
            if (d_done) begin
                if (prev) fail_now("d_done_width");
                if (d_q.size() == 0) fail_now("d_unexpected_done");
                else begin
                    e = d_q.pop_front();
                    check("d_flags", {d_gt, d_eq, d_lt}, e.flags);
                    check("d_latency", cyc, e.due);
                end
            end
            prev = d_done;
        end
    end

    task automatic d_issue(input logic [7:0] x, input logic [7:0] y, input logic sm);
        exp_t e;
        d_a = x; d_b = y; d_sm = sm; d_start = 1'b1;
        e.flags = ref_cmp(8, 32'(x), 32'(y), sm);
        e.due   = cyc + 1 + ref_lat(8, 2, 32'(x), 32'(y));
        d_q.push_back(e);
        @(negedge clk);
        d_start = 1'b0;
    endtask

    task automatic d_wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (d_q.size() == 0 && !d_busy) return;
            @(negedge clk);
        end
        fail_now("d_idle_wait");
        d_q.delete();
    endtask

    initial begin : d_driver
        repeat (2) @(negedge clk);
        check("reset_state", {d_busy, d_done, d_gt, d_eq, d_lt}, 5'b0);
        d_rst = 1'b0;
        @(negedge clk);

        // Reset while a compare is in flight: abandoned, no done.
        d_a = 8'hA5; d_b = 8'hA4; d_sm = 1'b0; d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        @(negedge clk);
        d_rst = 1'b1;
        #1;
        check("rst_mid_busy", d_busy, 0);
        @(negedge clk);
        d_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_mid_quiet", {d_busy, d_done, d_gt, d_eq, d_lt}, 5'b0);
        end

        d_issue(8'hA5, 8'hA4, 1'b0);   // gt after 4 chunks
        d_wait_idle();
        d_issue(8'h80, 8'h01, 1'b1);   // signed: lt after 1 chunk
        d_wait_idle();
        d_issue(8'h80, 8'h01, 1'b0);   // unsigned: gt after 1 chunk
        d_wait_idle();

        d_issue(8'h3C, 8'h3C, 1'b0);   // eq after 4 chunks
        d_wait_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("eq_hold", {d_done, d_busy, d_gt, d_eq, d_lt}, 5'b00010);
        end

        // Start while busy is ignored; start in the done cycle is accepted.
        d_issue(8'h5B, 8'h5A, 1'b0);   // gt after 4 chunks
        d_a = 8'h00; d_b = 8'hFF; d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (d_done) break;
            @(negedge clk);
        end
        d_issue(8'h12, 8'h34, 1'b0);
        check("b2b_busy", d_busy, 1);
        d_wait_idle();
        d_fin = 1'b1;
    end

    // ------------------------------------------------------------------
    // Randomized instances
    // ------------------------------------------------------------------
    for (genvar k = 0; k < 3; k++) begin : g_rnd
        localparam int W = (k == 0) ? 8 : (k == 1) ? 16 : 7;
        localparam int C = (k == 0) ? 2 : (k == 1) ? 4 : 1;

        logic         rst = 1'b1, start = 1'b0, sm = 1'b0;
        logic [W-1:0] a = '0, b = '0;
        logic         busy, done, gt, eq, lt;
        exp_t         q[$];
        bit           fin = 1'b0;

        mag_comp_seq #(.WIDTH(W), .CHUNK(C)) dut (
            .clk(clk), .rst(rst), .start(start), .signed_mode(sm),
            .a(a), .b(b), .busy(busy), .done(done),
            .gt(gt), .eq(eq), .lt(lt)
        );

        initial begin : driver
            exp_t e;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            for (int t = 0; t < 1000; ) begin
                if (!busy && $urandom_range(3) != 0) begin
                    a = W'($urandom);
                    case ($urandom_range(3))
                        0:       b = a;
                        1:       b = a ^ (W'(1) << $urandom_range(W - 1));
                        default: b = W'($urandom);
                    endcase
                    sm    = 1'($urandom);
                    start = 1'b1;
                    e.flags = ref_cmp(W, 32'(a), 32'(b), sm);
                    e.due   = cyc + 1 + ref_lat(W, C, 32'(a), 32'(b));
                    q.push_back(e);
                    t++;
                end else if (busy && $urandom_range(7) == 0) begin
                    a = W'($urandom); b = W'($urandom); sm = 1'($urandom);
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
            start = 1'b0;
            for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
            if (q.size() != 0) fail_now($sformatf("rnd%0d_drain", k));
            fin = 1'b1;
        end

        initial begin : monitor
            exp_t e;
            bit   prev = 1'b0;
            int   wait_cnt = 0;
            forever begin
                @(negedge clk);
                if (done) begin
                    if (prev) fail_now($sformatf("rnd%0d_done_width", k));
                    if (q.size() == 0) fail_now($sformatf("rnd%0d_unexpected_done", k));
                    else begin
                        e = q.pop_front();
                        check($sformatf("rnd%0d_flags", k), {gt, eq, lt}, e.flags);
                        check($sformatf("rnd%0d_latency", k), cyc, e.due);
                    end
                    wait_cnt = 0;
                end else if (q.size() != 0) begin
                    wait_cnt++;
                    if (wait_cnt > 4 * W) begin
                        fail_now($sformatf("rnd%0d_done_timeout", k));
                        q.delete();
                        wait_cnt = 0;
                    end
                end
                prev = done;
            end
        end
    end

    initial begin : finisher
        for (int i = 0; i < 50000; i++) begin
            @(posedge clk);
            if (d_fin && g_rnd[0].fin && g_rnd[1].fin && g_rnd[2].fin) break;
        end
        if (!(d_fin && g_rnd[0].fin && g_rnd[1].fin && g_rnd[2].fin))
            fail_now("global_timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
